// File: rtl/d_cache_pkg.sv
// rtl/d_cache_pkg.sv - shared constants and FSM encoding for the direct-mapped data cache
package d_cache_pkg;

  localparam int ADDR_W     = 30;
  localparam int TAG_W      = 25;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

endpackage

// File: rtl/d_cache_array.sv
// rtl/d_cache_array.sv - tag/valid/dirty/data storage with hit compare
module d_cache_array
  import d_cache_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  index,
  input  logic [TAG_W-1:0]    tag,
  output logic                hit,
  output logic                victim_dirty,
  output logic [TAG_W-1:0]    victim_tag,
  output logic [LINE_W-1:0]   line_data,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                fill_we,
  input  logic [LINE_W-1:0]   fill_data
);

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  // Line status bits: a fill makes the line valid and clean, a store hit marks it dirty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (word_we) begin
      dirty[index] <= 1'b1;
    end
  end

  // Tag and data storage need no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= fill_data;
    end else if (word_we) begin
      data_mem[index][{word_off, 5'd0} +: WORD_W] <= word_data;
    end
  end

  assign hit          = valid[index] && (tag_mem[index] == tag);
  assign victim_dirty = valid[index] && dirty[index];
  assign victim_tag   = tag_mem[index];
  assign line_data    = data_mem[index];

endmodule

// File: rtl/d_cache.sv
// rtl/d_cache.sv - direct-mapped write-back, write-allocate data cache with blocking miss FSM
module d_cache
  import d_cache_pkg::*;
#(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [ADDR_W-1:0]     proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  proc_stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  state_t                state, state_next;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;
  logic [OFFSET_W-1:0]   req_offset;
  logic                  req;
  logic                  hit;
  logic                  victim_dirty;
  logic [TAG_W-1:0]      victim_tag;
  logic [LINE_W-1:0]     line_data;
  logic                  word_we;
  logic                  fill_we;
  logic [WORD_W-1:0]     line_words [WORDS_PER_LINE];

  assign req_tag    = proc_addr[ADDR_W-1 -: TAG_W];
  assign req_index  = proc_addr[OFFSET_W +: INDEX_W];
  assign req_offset = proc_addr[OFFSET_W-1:0];
  // A request seen while reset is held must not raise a stall.
  assign req        = (proc_read || proc_write) && !rst;

  d_cache_array #(
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .index        (req_index),
    .tag          (req_tag),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .line_data    (line_data),
    .word_we      (word_we),
    .word_off     (req_offset),
    .word_data    (proc_wdata),
    .fill_we      (fill_we),
    .fill_data    (mem_rdata)
  );

  // Split the selected line into words so loads return the addressed word combinationally.
  always_comb begin
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      line_words[w] = line_data[w*WORD_W +: WORD_W];
    end
  end

  assign proc_rdata = line_words[req_offset];

  // State register; reset abandons any outstanding memory transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; proc_write wins when both request lines are high.
  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    proc_stall = 1'b0;
    word_we    = 1'b0;
    fill_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && !hit) begin
          proc_stall = 1'b1;
          state_next = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
        end else if (req && proc_write) begin
          word_we = 1'b1;
        end
      end
      S_WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {victim_tag, req_index};
        mem_wdata  = line_data;
        if (mem_ready) begin
          state_next = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {req_tag, req_index};
        if (mem_ready) begin
          fill_we    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/d_cache.md
D_CACHE -- requirements
Module: d_cache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter WORDS_PER_LINE, fixed at 4 words of 32 bits (128-bit line).
REQ-003 clk  input  1  clock; one clock; reset is asynchronous and active-high.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 proc_read  input  1  load request from the EX/MEM pipeline register.
REQ-006 proc_write  input  1  store request from the EX/MEM pipeline register.
REQ-007 proc_addr  input  30  word address: tag [29:5], index [4:2], offset [1:0].
REQ-008 proc_wdata  input  32  store data.
REQ-009 proc_rdata  output  32  load data, valid when proc_stall is low.
REQ-010 proc_stall  output  1  pipeline stall request.
REQ-011 mem_read  output  1  line-fill request to memory.
REQ-012 mem_write  output  1  line write-back request to memory.
REQ-013 mem_addr  output  28  line address {tag, index}.
REQ-014 mem_wdata  output  128  write-back line data.
REQ-015 mem_rdata  input  128  fill line data, valid when mem_ready is high.
REQ-016 mem_ready  input  1  one-cycle completion pulse for the outstanding mem_read or mem_write.

Function
REQ-017 Each line SHALL hold valid, dirty, a 25-bit tag and 128 data bits; a hit SHALL be valid && stored tag == proc_addr tag.
REQ-018 FSM states SHALL be IDLE, WRITEBACK and ALLOCATE.
REQ-019 IDLE: a request with no pending hit SHALL be a miss, asserting proc_stall in the same cycle (combinational).
REQ-020 Read hit in IDLE: proc_rdata SHALL be the addressed word in the same cycle, with proc_stall low (zero-latency).
REQ-021 Write hit in IDLE: the addressed word SHALL be written at the next edge, with dirty set and proc_stall low.
REQ-022 Miss in IDLE: dirty victim SHALL go to WRITEBACK; clean or invalid victim SHALL go to ALLOCATE.
REQ-023 WRITEBACK: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line, all held stable until mem_ready; on mem_ready SHALL go to ALLOCATE.
REQ-024 ALLOCATE: mem_read=1, mem_addr={request tag, index}, held until mem_ready; on mem_ready SHALL store mem_rdata, set valid, clear dirty, load tag, and go to IDLE.
REQ-025 After a fill the request SHALL be a hit in IDLE on the next cycle; a write then merges its word and sets dirty (write-allocate, write-back).
REQ-026 proc_stall SHALL be high in WRITEBACK and ALLOCATE, and in IDLE on a miss; low otherwise.
REQ-027 Processor SHALL hold proc_addr, proc_read, proc_write and proc_wdata stable while proc_stall is high; the cache is not required to tolerate changes.
REQ-028 proc_read and proc_write both high SHALL be treated as a write.
REQ-029 With no request, proc_stall SHALL be 0, and proc_rdata is don't-care but SHALL be deterministic (addressed word).
REQ-030 mem_read and mem_write SHALL never be high together; mem_ready outside WRITEBACK/ALLOCATE SHALL be ignored.

Reset
REQ-031 rst SHALL asynchronously force IDLE and clear all valid and dirty bits; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_stall=0.
REQ-032 rst mid-WRITEBACK/ALLOCATE SHALL abandon the transfer; a mem_ready arriving after reset SHALL be ignored.
REQ-033 Tag/data arrays need no reset.

Structure
REQ-034 A shared package SHALL hold the state encoding and the TAG_W, INDEX_W and LINE_W constants.
REQ-035 One sub-module, d_cache_array (tag/valid/dirty/data storage with hit compare), is natural; the FSM lives in d_cache.

Verification
REQ-036 After reset, read 0x0000010 -> stall, ALLOCATE with mem_addr=0x0000004; on mem_ready with line {D3,D2,D1,D0} -> next cycle proc_rdata=D0, stall=0.
REQ-037 Write 0xCAFEBABE to 0x0000011 on a resident line -> no stall, dirty set; read 0x0000011 -> 0xCAFEBABE.
REQ-038 Read 0x0000031 (same index, new tag) with dirty victim -> WRITEBACK with mem_addr=0x0000004 and mem_wdata word1=0xCAFEBABE, then ALLOCATE with mem_addr=0x000000C.
REQ-039 Miss with mem_ready delayed 10 cycles -> mem_* signals and stall held constant for all 10 cycles.
REQ-040 Assert rst during ALLOCATE, then pulse mem_ready -> IDLE, mem_read=0, and the old address now misses.
REQ-041 Simultaneous proc_read and proc_write on a hit -> treated as a write; mem_read and mem_write never both high throughout.
